// File: rtl/sdm_tx.sv
// Second-order sigma-delta bitstream transmitter with a programmable bit clock,
// a one-deep sample holding register and optional Manchester output.
module sdm_tx #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8,
    parameter int OSR_W  = 10
) (
    input  logic              EXTCLK,
    input  logic              EXTRSTn,
    input  logic              ENABLE,
    input  logic              MODE,
    input  logic [DIV_W-1:0]  CLKDIV,
    input  logic [OSR_W-1:0]  OSR,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              SDCLK,
    output logic              DSDOUT,
    output logic              UNDERRUN
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int I1_W = DATA_W + 2;
    localparam int I2_W = DATA_W + 4;
    localparam int SW   = DATA_W + 6;

    localparam logic signed [SW-1:0] FB_POS = {{(SW-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [SW-1:0] FB_NEG = -FB_POS;
    localparam logic signed [SW-1:0] I1_MAX = {{(SW-I1_W+1){1'b0}}, {(I1_W-1){1'b1}}};
    localparam logic signed [SW-1:0] I1_MIN = ~I1_MAX;
    localparam logic signed [SW-1:0] I2_MAX = {{(SW-I2_W+1){1'b0}}, {(I2_W-1){1'b1}}};
    localparam logic signed [SW-1:0] I2_MIN = ~I2_MAX;

    logic              state_q, state_d;
    logic [DIV_W-1:0]  clkdiv_q, clkdiv_d;
    logic [OSR_W-1:0]  osr_q, osr_d;
    logic              mode_q, mode_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [OSR_W-1:0]  bitcnt_q, bitcnt_d;
    logic              phase_q, phase_d;
    logic              bit_q, bit_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [I1_W-1:0]   i1_q, i1_d;
    logic [I2_W-1:0]   i2_q, i2_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              full_q, full_d;
    logic              ready_q, ready_d;
    logic              sdclk_q, sdclk_d;
    logic              dsdout_q, dsdout_d;
    logic              underrun_q, underrun_d;

    logic              running;
    logic              wrap;
    logic              update;
    logic              load;
    logic [DATA_W-1:0] x_eff;
    logic signed [SW-1:0] fb_w, e_w, i1_sum, i1_sat, i2_sum, i2_sat;

    assign running = (state_q == ST_RUN) && ENABLE;
    assign wrap    = (div_q == clkdiv_q);
    assign update  = running && wrap && phase_q;
    assign load    = update && (bitcnt_q == '0);
    // A sample loaded in this update is already used by this update's loop step
    assign x_eff   = (load && full_q) ? hold_q : x_q;

    always_comb begin
        fb_w   = bit_q ? FB_POS : FB_NEG;
        e_w    = {{(SW-DATA_W){x_eff[DATA_W-1]}}, x_eff} - fb_w;
        i1_sum = {{(SW-I1_W){i1_q[I1_W-1]}}, i1_q} + e_w;
        i1_sat = (i1_sum > I1_MAX) ? I1_MAX : ((i1_sum < I1_MIN) ? I1_MIN : i1_sum);
        i2_sum = {{(SW-I2_W){i2_q[I2_W-1]}}, i2_q} + i1_sat - fb_w;
        i2_sat = (i2_sum > I2_MAX) ? I2_MAX : ((i2_sum < I2_MIN) ? I2_MIN : i2_sum);
    end

    always_comb begin
        state_d    = state_q;
        clkdiv_d   = clkdiv_q;
        osr_d      = osr_q;
        mode_d     = mode_q;
        div_d      = '0;
        bitcnt_d   = '0;
        phase_d    = 1'b0;
        bit_d      = 1'b0;
        x_d        = x_q;
        i1_d       = '0;
        i2_d       = '0;
        hold_d     = hold_q;
        full_d     = full_q;
        underrun_d = 1'b0;

        if (state_q == ST_IDLE) begin
            if (ENABLE) begin
                state_d  = ST_RUN;
                clkdiv_d = CLKDIV;
                osr_d    = OSR;
                mode_d   = MODE;
            end
        end else if (!ENABLE) begin
            state_d = ST_IDLE;
        end else begin
            div_d    = wrap ? '0 : div_q + DIV_W'(1);
            phase_d  = wrap ? ~phase_q : phase_q;
            bitcnt_d = bitcnt_q;
            bit_d    = bit_q;
            i1_d     = i1_q;
            i2_d     = i2_q;
            if (update) begin
                bitcnt_d = (bitcnt_q == osr_q) ? '0 : bitcnt_q + OSR_W'(1);
                x_d      = x_eff;
                i1_d     = i1_sat[I1_W-1:0];
                i2_d     = i2_sat[I2_W-1:0];
                bit_d    = ~i2_sat[SW-1];
            end
        end

        // Load consumes the old content; a simultaneous accept refills it
        if (load) begin
            full_d     = 1'b0;
            underrun_d = ~full_q;
        end
        if (DIN_VALID && !full_q) begin
            hold_d = DIN;
            full_d = 1'b1;
        end

        ready_d  = ~full_d;
        sdclk_d  = mode_d ? 1'b0 : phase_d;
        dsdout_d = mode_d ? (bit_d ^ phase_d) : bit_d;
        if (state_d == ST_IDLE) begin
            sdclk_d  = 1'b0;
            dsdout_d = 1'b0;
        end
    end

    always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
        if (!EXTRSTn) begin
            state_q    <= ST_IDLE;
            clkdiv_q   <= '0;
            osr_q      <= '0;
            mode_q     <= 1'b0;
            div_q      <= '0;
            bitcnt_q   <= '0;
            phase_q    <= 1'b0;
            bit_q      <= 1'b0;
            x_q        <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            sdclk_q    <= 1'b0;
            dsdout_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clkdiv_q   <= clkdiv_d;
            osr_q      <= osr_d;
            mode_q     <= mode_d;
            div_q      <= div_d;
            bitcnt_q   <= bitcnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            x_q        <= x_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            sdclk_q    <= sdclk_d;
            dsdout_q   <= dsdout_d;
            underrun_q <= underrun_d;
        end
    end

    assign DIN_READY = ready_q;
    assign SDCLK     = sdclk_q;
    assign DSDOUT    = dsdout_q;
    assign UNDERRUN  = underrun_q;

endmodule

// File: doc/sdm_tx.md
SDM_TX -- requirements
Module: sdm_tx

Interface
REQ-001 Parameter DATA_W, default 16, sets the width of the signed two's-complement input sample.
REQ-002 Parameter DIV_W, default 8, sets the width of the clock-divider setting.
REQ-003 Parameter OSR_W, default 10, sets the width of the oversampling-ratio setting.
REQ-004 EXTCLK  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-005 EXTRSTn  in  1  asynchronous, active-low reset.
REQ-006 ENABLE  in  1  run request; high = modulate, low = idle.
REQ-007 MODE  in  1  0 = separate clock + data, 1 = Manchester (data XOR clock on DSDOUT).
REQ-008 CLKDIV  in  DIV_W  half-period of SDCLK, in EXTCLK cycles, minus 1.
REQ-009 OSR  in  OSR_W  modulator bits per input sample, minus 1.
REQ-010 DIN  in  DATA_W  signed input sample.
REQ-011 DIN_VALID  in  1  DIN is valid this cycle.
REQ-012 DIN_READY  out  1  holding register empty; DIN is accepted when DIN_VALID and DIN_READY are both high.
REQ-013 SDCLK  out  1  modulator bit clock; receiver samples DSDOUT on its rising edge.
REQ-014 DSDOUT  out  1  modulator bitstream.
REQ-015 UNDERRUN  out  1  one-cycle pulse when a sample load finds the holding register empty.

Function
REQ-016 States SHALL be IDLE and RUN: IDLE->RUN when ENABLE=1; RUN->IDLE in the cycle after ENABLE=0.
REQ-017 CLKDIV, OSR and MODE SHALL be captured on the IDLE->RUN transition and held constant throughout RUN.
REQ-018 In IDLE: SDCLK=0, DSDOUT=0, integrators=0, all counters=0, internal phase=0; the holding register SHALL be retained.
REQ-019 In RUN, the divider SHALL count 0..CLKDIV; on wrap it SHALL toggle the phase, giving a bit period of 2*(CLKDIV+1) EXTCLK cycles.
REQ-020 The first phase rise SHALL occur CLKDIV+1 cycles after entering RUN.
REQ-021 The modulator SHALL update exactly on each phase 1->0 toggle, with DSDOUT and the phase changing in the same cycle, so that data is stable around SDCLK rise.
REQ-022 Loop: e = x - fb; i1 += e; i2 += i1 - fb; bit = (i2 >= 0); fb = bit ? +2^(DATA_W-1) : -2^(DATA_W-1), using the bit from the previous update.
REQ-023 i1 SHALL be DATA_W+2 bits and i2 DATA_W+4 bits, both signed and saturating at their min/max; they SHALL never wrap.
REQ-024 A bit counter SHALL count modulator updates 0..OSR; at count 0 (including the first update after RUN entry), x SHALL be loaded from the holding register.
REQ-025 If the holding register is empty at a load, x SHALL keep its old value (0 after reset) and UNDERRUN SHALL pulse for one cycle.
REQ-026 DIN_READY SHALL equal NOT(holding full); full is set on accept and cleared on load.
REQ-027 An accept and a load in the same cycle SHALL load the old content and keep the register full with the new DIN.
REQ-028 MODE=0: SDCLK = phase, DSDOUT = bit.
REQ-029 MODE=1: SDCLK = 0 and DSDOUT = bit XOR phase.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-031 On EXTRSTn=0, immediately and irrespective of the clock: state=IDLE, SDCLK=0, DSDOUT=0, UNDERRUN=0, holding register empty, DIN_READY=1, integrators, x and counters all 0.
REQ-032 Reset asserted mid-RUN SHALL abort without completing the current bit, and no UNDERRUN SHALL be generated.

Verification
REQ-033 CLKDIV=1, MODE=0, ENABLE rises -> SDCLK rises 2 cycles later; SDCLK period = 4 EXTCLK; DSDOUT changes only in cycles where SDCLK falls.
REQ-034 DIN=0 supplied continuously, OSR=255 -> ones count over 1024 bits = 512±2; UNDERRUN never pulses.
REQ-035 DIN=+16384 (DATA_W=16) -> ones count over 1024 bits = 768±4; DIN=-16384 -> 256±4.
REQ-036 DIN=+32767 held for 4096 bits, then DIN=0 -> density ≥1020/1024 during the hold, and returns to 512±4 within 64 bits (saturation, no wrap).
REQ-037 No DIN supplied after the first sample, OSR=3 -> UNDERRUN pulses once every 4 bits and x holds the first sample; also check an accept in the same cycle as a load.
REQ-038 MODE=1 with DIN=0 -> SDCLK stays 0 and DSDOUT = bit XOR phase; EXTRSTn pulsed mid-bit -> all outputs go to 0 asynchronously and DIN_READY=1.
